// File: rtl/tick_scheduler_if.sv
// Bundle of configuration, control and status signals for tick_scheduler.
// The master side (controller or testbench) drives configuration and control.
// The slave side (the scheduler) drives the status outputs.
interface tick_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [1:0]       cfg_idx;
    logic [CNT_W-1:0] cfg_div;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic [1:0]       seg_idx;
    logic             done;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_idx, cfg_div, start, stop,
        input  busy, tick, seg_idx, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_div, start, stop,
        output busy, tick, seg_idx, done, cfg_err
    );
endinterface

// File: rtl/tick_scheduler.sv
// tick_scheduler: plays back four segments from a table of divide ratios.
// Each segment emits TICKS_PER_SEG one-cycle tick pulses, one every
// table[seg] cycles. A segment whose ratio is zero is skipped.
// The table can only be written while idle, so a running ratio never changes.
// Optional feature: define TICK_SCHEDULER_LOOP_EN to wrap from segment 3 back
// to segment 0 forever instead of finishing with a done pulse.
module tick_scheduler #(
    parameter int CNT_W         = 16,
    parameter int TICKS_PER_SEG = 8
) (
    input logic            clk,
    input logic            rst,
    tick_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       LAST_TICK = 8'(TICKS_PER_SEG - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tick_cnt_q, tick_cnt_d;
    logic [1:0]       seg_q, seg_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] table_q [4];
    logic [CNT_W-1:0] table_d [4];

    logic [CNT_W-1:0] cur_ratio;
    logic             last_cycle;
    state_t           adv_state;
    logic [1:0]       adv_seg;

    // The active ratio is read straight from the table; it is frozen while busy.
    assign cur_ratio  = table_q[seg_q];
    assign last_cycle = (state_q == RUN) && (cnt_q == (cur_ratio - CNT_ONE));

    // Status outputs come only from registered state.
    assign bus.busy    = (state_q != IDLE);
    assign bus.tick    = last_cycle;
    assign bus.done    = (state_q == DONE);
    assign bus.seg_idx = seg_q;
    assign bus.cfg_err = cfg_err_q;

    // Where to go when the current segment finishes or is skipped.
    always_comb begin
        adv_state = LOAD;
        adv_seg   = seg_q;
        if (seg_q != 2'd3) begin
            adv_state = LOAD;
            adv_seg   = seg_q + 2'd1;
        end else begin
`ifdef TICK_SCHEDULER_LOOP_EN
            adv_state = LOAD;
            adv_seg   = 2'd0;
`else
            adv_state = DONE;
            adv_seg   = seg_q;
`endif
        end
    end

    // Next-state, counters, table write and write-rejection logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_cnt_d = tick_cnt_q;
        seg_d      = seg_q;
        table_d    = table_q;
        cfg_err_d  = 1'b0;

        if (bus.cfg_we) begin
            if (state_q == IDLE) begin
                table_d[bus.cfg_idx] = bus.cfg_div;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    seg_d   = 2'd0;
                end
            end
            LOAD: begin
                cnt_d      = '0;
                tick_cnt_d = '0;
                if (cur_ratio != '0) begin
                    state_d = RUN;
                end else begin
                    state_d = adv_state;
                    seg_d   = adv_seg;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    if (tick_cnt_q == LAST_TICK) begin
                        state_d = adv_state;
                        seg_d   = adv_seg;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.stop) begin
            state_d    = IDLE;
            cnt_d      = '0;
            tick_cnt_d = '0;
            seg_d      = 2'd0;
        end
    end

    // State register; reset restores every table entry to ratio 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            seg_q      <= 2'd0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                table_q[i] <= CNT_ONE;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            seg_q      <= seg_d;
            cfg_err_q  <= cfg_err_d;
            table_q    <= table_d;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler (TICKS_PER_SEG=2, CNT_W=16).
// A reference model expands the ratio table into a list of expected per-cycle
// outputs when a sequence starts; each cycle the DUT outputs are compared
// against the head of that list.
module tb_tick_scheduler;

    localparam int CNT_W = 16;
    localparam int TPS   = 2;

    typedef struct packed {
        logic       busy;
        logic       tick;
        logic [1:0] seg;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;

    tick_scheduler_if #(.CNT_W(CNT_W)) bus ();

    tick_scheduler #(
        .CNT_W(CNT_W),
        .TICKS_PER_SEG(TPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fail_cnt  = 0;
    int   cyc       = 0;

    exp_t cur;
    exp_t seq_q[$];
    int   mdl_table[4];
    logic exp_err;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expand the ratio table into the expected cycle-by-cycle output list.
    function automatic void build_seq();
        exp_t e;
        seq_q.delete();
        for (int s = 0; s < 4; s++) begin
            e.busy = 1'b1; e.tick = 1'b0; e.seg = 2'(s); e.done = 1'b0;
            seq_q.push_back(e);
            if (mdl_table[s] != 0) begin
                for (int k = 0; k < TPS * mdl_table[s]; k++) begin
                    e.tick = (((k + 1) % mdl_table[s]) == 0);
                    seq_q.push_back(e);
                end
            end
        end
`ifndef TICK_SCHEDULER_LOOP_EN
        e.busy = 1'b1; e.tick = 1'b0; e.seg = 2'd3; e.done = 1'b1;
        seq_q.push_back(e);
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkOutput();
        check("busy",    16'(bus.busy),    16'(cur.busy));
        check("tick",    16'(bus.tick),    16'(cur.tick));
        check("seg_idx", 16'(bus.seg_idx), 16'(cur.seg));
        check("done",    16'(bus.done),    16'(cur.done));
        check("cfg_err", 16'(bus.cfg_err), 16'(exp_err));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input logic rst_i, input logic start_i, input logic stop_i,
                                 input logic we_i, input logic [1:0] idx_i,
                                 input logic [15:0] div_i);
        rst         = rst_i;
        bus.start   = start_i;
        bus.stop    = stop_i;
        bus.cfg_we  = we_i;
        bus.cfg_idx = idx_i;
        bus.cfg_div = div_i;
        @(posedge clk);
        if (rst_i) begin
            seq_q.delete();
            cur     = '0;
            exp_err = 1'b0;
            for (int i = 0; i < 4; i++) mdl_table[i] = 1;
        end else begin
            exp_err = we_i && cur.busy;
            if (we_i && !cur.busy) mdl_table[idx_i] = int'(div_i);
            if (stop_i) begin
                seq_q.delete();
                cur = '0;
            end else if (!cur.busy) begin
                if (start_i) begin
                    build_seq();
                    cur = seq_q.pop_front();
                end
            end else if (seq_q.size() == 0) begin
`ifdef TICK_SCHEDULER_LOOP_EN
                build_seq();
                cur = seq_q.pop_front();
`else
                cur.busy = 1'b0; cur.tick = 1'b0; cur.done = 1'b0;
`endif
            end else begin
                cur = seq_q.pop_front();
            end
        end
        cyc++;
        #1;
        checkOutput();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    endtask

    task automatic write_table(input int a, input int b, input int c, input int d);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'(a));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'(b));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'(c));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'(d));
    endtask

    int tick_cyc[8];
    int exp_ticks[8];
    int n_ticks;
    int done_cyc;
    int busy_low_cyc;
    logic r_rst, r_start, r_stop, r_we;

    // Directed scenarios followed by a randomized phase.
    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = 2'd0; bus.cfg_div = '0;
        cur = '0; exp_err = 1'b0;
        for (int i = 0; i < 4; i++) mdl_table[i] = 1;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(2);

        $display("[TB] table {3,1,2,4} timing");
        write_table(3, 1, 2, 4);
        exp_ticks = '{4, 7, 9, 10, 13, 15, 20, 24};
        n_ticks = 0; done_cyc = -1; busy_low_cyc = -1;
        cyc = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        for (int c = 2; c <= 28; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
            if (bus.tick && n_ticks < 8) begin
                tick_cyc[n_ticks] = cyc;
                n_ticks++;
            end
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            if (!bus.busy && busy_low_cyc < 0) busy_low_cyc = cyc;
        end
        check("tick_count", 16'(n_ticks), 16'd8);
        for (int i = 0; i < 8; i++) check("tick_cycle", 16'(tick_cyc[i]), 16'(exp_ticks[i]));
`ifndef TICK_SCHEDULER_LOOP_EN
        check("done_cycle", 16'(done_cyc), 16'd25);
        check("busy_low_cycle", 16'(busy_low_cyc), 16'd26);
`endif

        $display("[TB] skipped segments {0,0,2,0}");
        write_table(0, 0, 2, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(12);

        $display("[TB] stop during segment 1");
        write_table(2, 3, 2, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        idle_cycles(10);

        $display("[TB] rejected write while busy");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(36);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(36);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
        idle_cycles(14);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stop  = ($urandom_range(0, 49) == 0);
            r_start = ($urandom_range(0, 5) == 0);
            r_we    = !r_stop && ($urandom_range(0, 3) == 0);
            applyStimulus(r_rst, r_start, r_stop, r_we, 2'($urandom_range(0, 3)),
                          16'($urandom_range(0, 3)));
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
